uart_rx_ext: RTL
================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, which SHALL be at least 8.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits checked, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-008 SHALL have port rx, input, 1 bit, asynchronous serial line that idles high.
REQ-009 SHALL have port rx_data, output, DATA_BITS wide, received word, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit, rx_data and the error flags hold an unread frame.
REQ-011 SHALL have port rx_ready, input, 1 bit, consumer accepts the frame when rx_valid && rx_ready.
REQ-012 SHALL have port frame_err, output, 1 bit, a stop bit sampled low; qualified by rx_valid.
REQ-013 SHALL have port parity_err, output, 1 bit, parity mismatch; qualified by rx_valid; always 0 when PARITY=0.
REQ-014 SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP, with bit counter clk_cnt of width $clog2(CLKS_PER_BIT) and bit index bit_idx.
REQ-017 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL enter START with clk_cnt=0; a line held low SHALL NOT retrigger.
REQ-018 In START at clk_cnt==CLKS_PER_BIT/2, rx_s==1 SHALL return to IDLE (false start, no output); otherwise SHALL clear clk_cnt and enter DATA with bit_idx=0.
REQ-019 In DATA/PARITY/STOP each bit SHALL be sampled at clk_cnt==CLKS_PER_BIT-1, then clk_cnt cleared, giving mid-bit sampling.
REQ-020 DATA SHALL shift samples in LSB first; after DATA_BITS samples it SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY SHALL compute parity_err = (XOR of data bits ^ parity bit) != (PARITY==1 ? 1 : 0).
REQ-022 STOP SHALL sample STOP_BITS bits; any low sample SHALL set frame_err for the frame; after the last stop sample the FSM SHALL return to IDLE in the same cycle.
REQ-023 Frame completion SHALL load rx_data, frame_err and parity_err and set rx_valid on the next cycle (latency one clk after the last stop-bit sample).
REQ-024 rx_valid SHALL clear on the cycle after rx_valid && rx_ready unless a new frame completes that same cycle, in which case the new frame SHALL load, rx_valid SHALL stay 1 and there SHALL be no overrun.
REQ-025 Completion while rx_valid=1 and rx_ready=0 SHALL drop the new frame, keep the held frame, and pulse overrun for 1 cycle.
REQ-026 A frame with frame_err SHALL still be delivered; a break (line held low) SHALL yield one frame with frame_err and no further frames until rx_s returns high.

Reset
REQ-027 rst_n=0 at a clk edge SHALL force IDLE, clear clk_cnt, bit_idx and the shift register, set rx_data=0, rx_valid=0, frame_err=0, parity_err=0 and overrun=0, and preset the synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception SHALL resume only on a fresh falling edge after release.

Configuration
REQ-029 With macro UART_RX_MAJORITY_EN defined, each bit (start included) SHALL be the 2-of-3 majority of rx_s at clk_cnt = sample-1, sample and sample+1.
REQ-030 Without UART_RX_MAJORITY_EN, each bit SHALL be the single rx_s sample at the sample point; sample timing, states and latency are identical in both builds.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state encoding, the PARITY encodings (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) and the CLKS_PER_BIT function.
REQ-032 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer plus falling-edge detect; everything else SHALL be in uart_rx_ext.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=100_000, 16 clk/bit)
REQ-033 8N1, byte 0x55 then 0xA3 with rx_ready=1 SHALL produce two rx_valid beats with rx_data=0x55 then 0xA3 and no error flags.
REQ-034 PARITY=2, DATA_BITS=7: 0x41 sent with parity 0 SHALL give parity_err=0; the same frame with parity 1 SHALL give parity_err=1 and rx_data=0x41.
REQ-035 A 6-clk low glitch on an idle line SHALL produce no rx_valid, and a following valid 0x3C SHALL be received correctly.
REQ-036 With rx_ready=0 and two frames 0x11 then 0x22, the second SHALL pulse overrun and rx_data SHALL remain 0x11 until accepted.
REQ-037 STOP_BITS=2 with the second stop bit low on 0xF0 SHALL give frame_err=1 with rx_data=0xF0.
REQ-038 rst_n pulsed low at data bit 4 of 0x99 SHALL produce no output, and a subsequent 0x66 SHALL be received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity modes, bit timing.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Parity selection values for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // System clocks per serial bit
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synchronized value.
// Latency: rx_s trails rx by 2 clk; rx_fall is asserted the first cycle rx_s reads 0 after a 1.
// Backpressure: none, free-running.
//
// Ports: clk, rst_n (synchronous, active-low) | rx (async line) |
//        rx_s (synchronized line), rx_fall (1->0 on rx_s) |
//        rx_s_prev / rx_s_next (only with UART_RX_MAJORITY_EN): rx_s one cycle
//        earlier and the value rx_s will take on the next cycle.
// Build option: UART_RX_MAJORITY_EN exposes the 3-sample window used for voting.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
`ifdef UART_RX_MAJORITY_EN
  output logic rx_s_prev,
  output logic rx_s_next,
`endif
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All three flops preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

`ifdef UART_RX_MAJORITY_EN
  // meta_q is exactly what rx_s will be next cycle, which lets the vote
  // centre on the sample point without moving the sample point itself.
  assign rx_s_prev = prev_q;
  assign rx_s_next = meta_q;
`endif

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: start detect, mid-bit sampling, optional parity, 1-2 stop bits, held output word.
// Latency: rx_valid rises 1 clk after the last stop-bit sample.
// Backpressure: valid/ready hold register; a frame completing while held and not accepted is dropped with a 1-clk overrun pulse.
//
// Ports: clk, rst_n (synchronous, active-low) | rx (async serial line, idle high) |
//        rx_data/rx_valid/rx_ready (output word handshake) |
//        frame_err, parity_err (qualified by rx_valid) | overrun (1-clk pulse).
// Build option: UART_RX_MAJORITY_EN -- each bit is the 2-of-3 vote of rx_s at
//        sample-1, sample, sample+1; timing and latency are unchanged.
module uart_rx_ext #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic rx_s;
  logic rx_fall;
  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic rx_s_prev;
  logic rx_s_next;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_s_prev (rx_s_prev),
    .rx_s_next (rx_s_next),
    .rx_s      (rx_s),
    .rx_fall   (rx_fall)
  );

  assign bit_val = (rx_s_prev & rx_s) | (rx_s & rx_s_next) | (rx_s_prev & rx_s_next);
`else
  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign bit_val = rx_s;
`endif

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  logic                 frame_done;
  logic                 frame_ferr;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;

  wire at_mid  = (clk_cnt_q == CNT_HALF);
  wire at_last = (clk_cnt_q == CNT_LAST);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_fall) state_d = ST_START;
      ST_START:  if (at_mid) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (at_last && (bit_idx_q == DATA_LAST))
                   state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_last) state_d = ST_STOP;
      ST_STOP:   if (at_last && (bit_idx_q == STOP_LAST)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath / output logic ----------------
  always_comb begin
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    // Frame error including the stop sample being taken this cycle.
    frame_ferr = ferr_q | ~bit_val;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
      end
      ST_START: begin
        if (at_mid) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (at_last) begin
          clk_cnt_d = '0;
          // Shift in from the top so the first (LSB) bit ends at bit 0.
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_idx_d = (bit_idx_q == DATA_LAST) ? '0 : bit_idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (at_last) begin
          clk_cnt_d = '0;
          perr_d    = ((^shift_q) ^ bit_val) != (PARITY == PAR_ODD);
        end
      end
      ST_STOP: begin
        if (at_last) begin
          clk_cnt_d  = '0;
          ferr_d     = frame_ferr;
          bit_idx_d  = bit_idx_q + 1'b1;
          frame_done = (bit_idx_q == STOP_LAST);
        end
      end
      default: clk_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // ---------------- output hold register ----------------
  // A completing frame may replace the held one only if it is being
  // accepted this same cycle (or nothing is held); otherwise it is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          frame_err_q  <= frame_ferr;
          parity_err_q <= (PARITY != PAR_NONE) && perr_q;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
